// File: rtl/dbn_pkg.sv
// Shared definitions for the DBN hidden-unit sampler.
//   - Q-format widths for the Q4.12 pre-activation and the Q1.16 sigmoid output
//   - PLAN sigmoid breakpoints (Q4.12 magnitudes) and segment offsets (Q1.16)
//   - Sampler FSM state enum
//   - Galois LFSR tap mask (used only when DBN_STOCH_SAMPLE_EN is defined)
//   - Saturating helpers for the Q4.12 datapath
package dbn_pkg;

    localparam int unsigned QxW    = 16;  // Q4.12 signed
    localparam int unsigned QxFrac = 12;
    localparam int unsigned QyW    = 17;  // Q1.16 unsigned

    // Segment breakpoints on |x|, Q4.12.
    localparam logic [14:0] BrkSat = 15'd20480;  // 5.0
    localparam logic [14:0] BrkHi  = 15'd9728;   // 2.375
    localparam logic [14:0] BrkLo  = 15'd4096;   // 1.0

    // Segment offsets, Q1.16.
    localparam logic [QyW-1:0] YOne   = 17'h10000;  // 1.0
    localparam logic [QyW-1:0] OffHi  = 17'd55296;  // 0.84375
    localparam logic [QyW-1:0] OffMid = 17'd40960;  // 0.625
    localparam logic [QyW-1:0] OffLo  = 17'd32768;  // 0.5

    localparam logic [15:0] ProbHalf = 16'h8000;
    localparam logic [15:0] LfsrTaps = 16'hB400;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    // Clamp a 32-bit signed value into the signed 16-bit Q4.12 range.
    function automatic logic [QxW-1:0] sat_to_q4_12(input logic signed [31:0] v);
        if (v > 32'sd32767) return 16'h7FFF;
        if (v < -32'sd32768) return 16'h8000;
        return v[15:0];
    endfunction

    // Signed 16-bit add, saturating to [0x8000, 0x7FFF].
    function automatic logic [QxW-1:0] sat_add_q4_12(input logic [QxW-1:0] a,
                                                     input logic [QxW-1:0] b);
        logic [QxW:0] s;
        s = {a[QxW-1], a} + {b[QxW-1], b};
        if (s[QxW] != s[QxW-1]) return s[QxW] ? 16'h8000 : 16'h7FFF;
        return s[QxW-1:0];
    endfunction

endpackage

// File: rtl/dbn_sigmoid_plan.sv
// PLAN piecewise-linear sigmoid, purely combinational.
// Ports:
//   x_i    in  16  signed Q4.12 activation
//   prob_o out 16  unsigned Q0.16 sigmoid value, clamped to 0xFFFF
// The curve is built for |x| and mirrored (1 - y) for negative inputs.
module dbn_sigmoid_plan
    import dbn_pkg::*;
(
    input  logic [QxW-1:0] x_i,
    output logic [15:0]    prob_o
);

    logic [14:0]    mag;
    logic [QyW-1:0] y;
    logic [QyW-1:0] res;

    always_comb begin
        // |x|; the most negative code has no positive twin, so pin it to 0x7FFF.
        if (x_i == 16'h8000) begin
            mag = 15'h7FFF;
        end else if (x_i[15]) begin
            mag = ~x_i[14:0] + 15'd1;
        end else begin
            mag = x_i[14:0];
        end

        // Slopes 1/32, 1/8, 1/4 applied to a Q4.12 magnitude landing in Q1.16
        // become shifts by -1, +1, +2.
        if (mag >= BrkSat) begin
            y = YOne;
        end else if (mag >= BrkHi) begin
            y = OffHi + 17'(mag >> 1);
        end else if (mag >= BrkLo) begin
            y = OffMid + 17'({mag, 1'b0});
        end else begin
            y = OffLo + 17'({mag, 2'b00});
        end

        res    = x_i[15] ? (YOne - y) : y;
        prob_o = res[16] ? 16'hFFFF : res[15:0];
    end

endmodule

// File: rtl/dbn_hidden_sampler.sv
// DBN hidden-layer sampler: bias add, PLAN sigmoid, binary hidden-state draw.
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   start                     begin a layer (IDLE only)
//   bias_we/bias_addr/data    bias RAM write, Q4.12 (IDLE only)
//   in_valid/in_ready/in_data Q8.24 pre-activation stream
//   out_valid/out_ready       result handshake
//   out_prob/out_bit/out_idx  Q0.16 probability, sampled state, unit index
//   layer_done                one-cycle pulse after the last unit's handshake
// Configuration macro: DBN_STOCH_SAMPLE_EN selects LFSR-based stochastic sampling;
// without it the hidden state is the deterministic threshold prob >= 0.5.
// Pipe: S1 bias add | S2 hold x | S3 sigmoid result | S4 bit + output regs.
module dbn_hidden_sampler
    import dbn_pkg::*;
#(
    parameter int unsigned NUM_HIDDEN = 64,
    parameter int unsigned IDX_W      = 6,
    parameter int unsigned FRAC_IN    = 24,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bias_we,
    input  logic [IDX_W-1:0] bias_addr,
    input  logic [15:0]      bias_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_prob,
    output logic             out_bit,
    output logic [IDX_W-1:0] out_idx,
    output logic             layer_done
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_HIDDEN - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] in_idx_q, in_idx_d;
    logic [15:0]      bias_mem_q [NUM_HIDDEN];

    logic              adv;
    logic              accept;
    logic              out_hs;
    logic signed [31:0] in_shift;
    logic [QxW-1:0]    x_biased;
    logic [15:0]       sig_prob;
    logic              bit_calc;

    logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic             s3_valid_q, s3_valid_d, s4_valid_q, s4_valid_d;
    logic [QxW-1:0]   s1_x_q, s1_x_d, s2_x_q, s2_x_d;
    logic [15:0]      s3_prob_q, s3_prob_d, s4_prob_q, s4_prob_d;
    logic             s4_bit_q, s4_bit_d;
    logic [IDX_W-1:0] s1_idx_q, s1_idx_d, s2_idx_q, s2_idx_d;
    logic [IDX_W-1:0] s3_idx_q, s3_idx_d, s4_idx_q, s4_idx_d;

    // Whole pipe advances together; a stalled output freezes every stage.
    assign adv      = !s4_valid_q || out_ready;
    assign in_ready = (state_q == StRun) && adv;
    assign accept   = in_valid && in_ready;
    assign out_hs   = s4_valid_q && out_ready;

    // Q8.24 -> Q4.12, then bias add, both saturating.
    assign in_shift = $signed(in_data) >>> (FRAC_IN - QxFrac);
    assign x_biased = sat_add_q4_12(sat_to_q4_12(in_shift), bias_mem_q[in_idx_q]);

    dbn_sigmoid_plan u_sigmoid (
        .x_i    (s2_x_q),
        .prob_o (sig_prob)
    );

`ifdef DBN_STOCH_SAMPLE_EN
    logic [15:0] lfsr_q, lfsr_d;

    // One LFSR step per unit moving S3 -> S4, so each unit sees a fresh draw.
    always_comb begin
        lfsr_d = lfsr_q;
        if (adv && s3_valid_q) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrTaps : 16'h0000);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign bit_calc = s3_prob_q > lfsr_q;
`else
    assign bit_calc = s3_prob_q >= ProbHalf;

    // SEED only seeds the stochastic sampler; nothing to build here.
    if (SEED == 16'h0000) begin : g_seed_unused
    end
`endif

    always_comb begin
        state_d  = state_q;
        in_idx_d = in_idx_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StRun;
                    in_idx_d = '0;
                end
            end
            StRun: begin
                if (accept) begin
                    in_idx_d = in_idx_q + IDX_W'(1);
                    if (in_idx_q == LastIdx) state_d = StDrain;
                end
            end
            StDrain: begin
                if (out_hs && (s4_idx_q == LastIdx)) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_x_d     = s1_x_q;
        s1_idx_d   = s1_idx_q;
        s2_valid_d = s2_valid_q;
        s2_x_d     = s2_x_q;
        s2_idx_d   = s2_idx_q;
        s3_valid_d = s3_valid_q;
        s3_prob_d  = s3_prob_q;
        s3_idx_d   = s3_idx_q;
        s4_valid_d = s4_valid_q;
        s4_prob_d  = s4_prob_q;
        s4_bit_d   = s4_bit_q;
        s4_idx_d   = s4_idx_q;
        if (adv) begin
            s1_valid_d = accept;
            s1_x_d     = x_biased;
            s1_idx_d   = in_idx_q;
            s2_valid_d = s1_valid_q;
            s2_x_d     = s1_x_q;
            s2_idx_d   = s1_idx_q;
            s3_valid_d = s2_valid_q;
            s3_prob_d  = sig_prob;
            s3_idx_d   = s2_idx_q;
            s4_valid_d = s3_valid_q;
            s4_prob_d  = s3_prob_q;
            s4_bit_d   = bit_calc;
            s4_idx_d   = s3_idx_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            in_idx_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_idx_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_x_q     <= '0;
            s2_idx_q   <= '0;
            s3_valid_q <= 1'b0;
            s3_prob_q  <= '0;
            s3_idx_q   <= '0;
            s4_valid_q <= 1'b0;
            s4_prob_q  <= '0;
            s4_bit_q   <= 1'b0;
            s4_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            in_idx_q   <= in_idx_d;
            s1_valid_q <= s1_valid_d;
            s1_x_q     <= s1_x_d;
            s1_idx_q   <= s1_idx_d;
            s2_valid_q <= s2_valid_d;
            s2_x_q     <= s2_x_d;
            s2_idx_q   <= s2_idx_d;
            s3_valid_q <= s3_valid_d;
            s3_prob_q  <= s3_prob_d;
            s3_idx_q   <= s3_idx_d;
            s4_valid_q <= s4_valid_d;
            s4_prob_q  <= s4_prob_d;
            s4_bit_q   <= s4_bit_d;
            s4_idx_q   <= s4_idx_d;
        end
    end

    // Bias RAM keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (bias_we && (state_q == StIdle)) begin
            bias_mem_q[bias_addr] <= bias_data;
        end
    end

    assign out_valid  = s4_valid_q;
    assign out_prob   = s4_prob_q;
    assign out_bit    = s4_bit_q;
    assign out_idx    = s4_idx_q;
    assign layer_done = (state_q == StDone);

endmodule

// File: tb/tb_dbn_hidden_sampler.sv
// Self-checking bench for dbn_hidden_sampler: directed vector table, randomized layers
// against a real-arithmetic sigmoid model, reset-abort sequence and, with
// DBN_STOCH_SAMPLE_EN defined, LFSR sampling statistics and repeatability.
module tb_dbn_hidden_sampler;

    localparam int unsigned NH   = 64;
    localparam int unsigned IW   = 6;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          NTAB = 18;

    logic          clk = 1'b0;
    logic          rst, start, bias_we;
    logic [IW-1:0] bias_addr;
    logic [15:0]   bias_data;
    logic          in_valid, in_ready;
    logic [31:0]   in_data;
    logic          out_valid, out_ready;
    logic [15:0]   out_prob;
    logic          out_bit;
    logic [IW-1:0] out_idx;
    logic          layer_done;

    always #5 clk = ~clk;

    dbn_hidden_sampler #(
        .NUM_HIDDEN (NH),
        .IDX_W      (IW),
        .FRAC_IN    (24),
        .SEED       (SEED)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bias_we    (bias_we),
        .bias_addr  (bias_addr),
        .bias_data  (bias_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_prob   (out_prob),
        .out_bit    (out_bit),
        .out_idx    (out_idx),
        .layer_done (layer_done)
    );

    typedef struct {
        logic [31:0] data;
        logic [15:0] bias;
        logic [15:0] prob;
        logic        bitv;
    } vec_t;

    typedef struct {
        logic [15:0]   prob;
        logic [IW-1:0] idx;
        int            tab_i;
    } exp_t;

    vec_t        tab [NTAB];
    exp_t        q [$];
    logic [15:0] bias_sh [NH];
    logic [15:0] lfsr_m;
    logic        bit_log [$];
    bit          rec_on;
    int          n_checks, n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Sigmoid reference straight from the segment formulas, in real arithmetic.
    function automatic logic [15:0] model_prob(input logic [31:0] d, input logic [15:0] b);
        int  x, ai, yq, res;
        real a, y;
        x = int'($floor(real'($signed(d)) / 4096.0));
        if (x > 32767) x = 32767;
        if (x < -32768) x = -32768;
        x = x + int'($signed(b));
        if (x > 32767) x = 32767;
        if (x < -32768) x = -32768;
        ai = (x < 0) ? -x : x;
        if (ai > 32767) ai = 32767;
        a = real'(ai) / 4096.0;
        if (a >= 5.0) y = 1.0;
        else if (a >= 2.375) y = a / 32.0 + 0.84375;
        else if (a >= 1.0) y = a / 8.0 + 0.625;
        else y = a / 4.0 + 0.5;
        yq  = int'($floor(y * 65536.0));
        res = (x >= 0) ? yq : 65536 - yq;
        if (res > 65535) res = 65535;
        return 16'(res);
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [31:0] rand_data();
        logic signed [31:0] r;
        r = $urandom();
        return r >>> $urandom_range(4, 8);
    endfunction

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; bias_we = 1'b0; bias_addr = '0; bias_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        lfsr_m = SEED;
    endtask

    // mode: 0 random biases, 1 table biases, 2 all zero
    task automatic program_biases(input int mode);
        logic signed [15:0] sb;
        for (int i = 0; i < NH; i++) begin
            sb = 16'($urandom());
            sb = sb >>> $urandom_range(0, 4);
            if (mode == 1 && i < NTAB) sb = tab[i].bias;
            if (mode == 2) sb = '0;
            bias_sh[i] = sb;
            bias_we = 1'b1; bias_addr = IW'(i); bias_data = sb;
            @(posedge clk); #1;
        end
        bias_we = 1'b0;
    endtask

    // rdy_mode: 0 always ready, 1 toggle, 2 random. data_mode: 0 random, 1 table, 2 zero.
    task automatic run_layer(input int rdy_mode, input int data_mode, input bit noisy);
        int          sent, got, acc0, last_hs, lim, ti;
        bit          done_seen, ready_late, need_new;
        logic [31:0] cur;
        logic        exp_bit;
        exp_t        e;
        sent = 0; got = 0; acc0 = -1; last_hs = -1; ti = -1;
        done_seen = 0; ready_late = 0; need_new = 1; cur = '0;
        q.delete();
        start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (lim = 0; lim < 2000 && !done_seen; lim++) begin
            if (need_new && sent < NH) begin
                ti = -1;
                if (data_mode == 1 && sent < NTAB) begin
                    cur = tab[sent].data; ti = sent;
                end else if (data_mode == 2) begin
                    cur = '0;
                end else begin
                    cur = rand_data();
                end
                need_new = 0;
            end
            in_data  = cur;
            in_valid = (sent < NH && noisy) ? ($urandom_range(0, 3) != 0) : 1'b1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (lim % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (noisy) begin
                start     = 1'($urandom_range(0, 1));
                bias_we   = 1'($urandom_range(0, 1));
                bias_addr = IW'($urandom_range(0, NH - 1));
                bias_data = 16'($urandom());
            end
            @(negedge clk);
            if (sent == NH && in_ready) ready_late = 1;
            if (in_valid && in_ready && sent < NH) begin
                q.push_back('{model_prob(cur, bias_sh[sent]), IW'(sent), ti});
                if (sent == 0) acc0 = lim;
                sent++;
                need_new = 1;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_output", 32'(out_valid), 32'(0));
                end else begin
                    e = q.pop_front();
                    got++;
`ifdef DBN_STOCH_SAMPLE_EN
                    exp_bit = e.prob > lfsr_m;
                    lfsr_m  = lfsr_next(lfsr_m);
`else
                    exp_bit = e.prob >= 16'h8000;
                    if (e.tab_i >= 0) check("table_bit", 32'(out_bit), 32'(tab[e.tab_i].bitv));
`endif
                    if (e.tab_i >= 0) check("table_prob", 32'(out_prob), 32'(tab[e.tab_i].prob));
                    check("out_idx", 32'(out_idx), 32'(e.idx));
                    check("out_prob", 32'(out_prob), 32'(e.prob));
                    check("out_bit", 32'(out_bit), 32'(exp_bit));
                    if (rdy_mode == 0 && e.idx == 0) check("latency_accept_to_valid", 32'(lim - acc0), 32'(4));
                    if (e.idx == IW'(NH - 1)) last_hs = lim;
                    if (rec_on) bit_log.push_back(out_bit);
                end
            end
            if (layer_done) begin
                done_seen = 1;
                check("layer_done_cycle", 32'(lim), 32'(last_hs + 1));
            end
            @(posedge clk); #1;
        end
        start = 1'b0; bias_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("layer_done_seen", 32'(done_seen), 32'(1));
        check("units_out", 32'(got), 32'(NH));
        check("in_ready_after_last_accept", 32'(ready_late), 32'(0));
        @(negedge clk);
        check("layer_done_single_pulse", 32'(layer_done), 32'(0));
        check("out_valid_idle", 32'(out_valid), 32'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        int          ones, diffs;
        bit          bad;
        logic        first_log [$];
        n_checks = 0; n_fail = 0; rec_on = 0;

        tab[0]  = '{32'h0000_0000, 16'h0000, 16'h8000, 1'b1};
        tab[1]  = '{32'h0100_0000, 16'h0000, 16'hC000, 1'b1};
        tab[2]  = '{32'hFF00_0000, 16'h0000, 16'h4000, 1'b0};
        tab[3]  = '{32'h7FFF_FFFF, 16'h0000, 16'hFFFF, 1'b1};
        tab[4]  = '{32'h8000_0000, 16'h0000, 16'h0000, 1'b0};
        tab[5]  = '{32'h0080_0000, 16'h0000, 16'hA000, 1'b1};
        tab[6]  = '{32'h0000_0000, 16'h1000, 16'hC000, 1'b1};
        tab[7]  = '{32'h0500_0000, 16'h0000, 16'hFFFF, 1'b1};
        tab[8]  = '{32'h0260_0000, 16'h0000, 16'hEB00, 1'b1};
        tab[9]  = '{32'hFDA0_0000, 16'h0000, 16'h1500, 1'b0};
        tab[10] = '{32'h7FFF_FFFF, 16'h7FFF, 16'hFFFF, 1'b1};
        tab[11] = '{32'h8000_0000, 16'h8000, 16'h0000, 1'b0};
        tab[12] = '{32'h04FF_F000, 16'h0000, 16'hFFFF, 1'b1};
        tab[13] = '{32'h00FF_F000, 16'h0000, 16'hBFFC, 1'b1};
        tab[14] = '{32'h025F_F000, 16'h0000, 16'hEBFE, 1'b1};
        tab[15] = '{32'hFF80_0000, 16'h0000, 16'h6000, 1'b0};
        tab[16] = '{32'h0000_0000, 16'hF000, 16'h4000, 1'b0};
        tab[17] = '{32'h0700_0000, 16'h2000, 16'hFFFF, 1'b1};

        do_reset();
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'(0));
        check("reset_in_ready", 32'(in_ready), 32'(0));
        check("reset_layer_done", 32'(layer_done), 32'(0));
        check("reset_out_prob", 32'(out_prob), 32'(0));
        check("reset_out_bit", 32'(out_bit), 32'(0));
        check("reset_out_idx", 32'(out_idx), 32'(0));
        @(posedge clk); #1;

        program_biases(1);
        run_layer(0, 1, 0);
        program_biases(0);
        run_layer(1, 0, 1);
        run_layer(2, 0, 1);

        // Abort a layer with three units in flight.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        lfsr_m = SEED;
        @(negedge clk);
        check("abort_out_valid", 32'(out_valid), 32'(0));
        check("abort_in_ready_idle", 32'(in_ready), 32'(0));
        check("abort_layer_done", 32'(layer_done), 32'(0));
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (layer_done || out_valid || in_ready) bad = 1;
        end
        check("abort_stays_idle", 32'(bad), 32'(0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        run_layer(2, 0, 0);

`ifdef DBN_STOCH_SAMPLE_EN
        program_biases(2);
        rec_on = 1;
        bit_log.delete();
        repeat (64) run_layer(0, 2, 0);
        ones = 0;
        foreach (bit_log[i]) ones += int'(bit_log[i]);
        check("ones_count_in_band", 32'(ones >= 1920 && ones <= 2176), 32'(1));
        first_log = bit_log;
        bit_log.delete();
        do_reset();
        repeat (64) run_layer(0, 2, 0);
        check("repeat_run_length", 32'(bit_log.size()), 32'(first_log.size()));
        diffs = 0;
        foreach (first_log[i]) if (i < bit_log.size() && bit_log[i] !== first_log[i]) diffs++;
        check("repeat_seed_stream", 32'(diffs), 32'(0));
        rec_on = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
